// File: rtl/mca_spectrum_accumulator.sv
// rtl/mca_spectrum_accumulator.sv - MCA pulse-height histogram: edge detect, delayed sample, bin increment, host read/clear
`timescale 1ns/1ps
module mca_spectrum_accumulator #(
    parameter int ADDR_W       = 10,
    parameter int COUNT_W      = 24,
    parameter int SAMPLE_DELAY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               comparator,
    input  logic [ADDR_W-1:0]  adc_code,
    input  logic               acq_enable,
    input  logic               clear_req,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COUNT_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               busy,
    output logic [31:0]        total_count,
    output logic [15:0]        dropped_count
);
    localparam int NBINS = 1 << ADDR_W;
    localparam int DLY_W = $clog2(SAMPLE_DELAY + 1);

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_READ, S_WRITE, S_HOST_RD, S_HOST_RSP
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q, prev_q;
    logic                dly_run_q;
    logic [DLY_W-1:0]    dly_cnt_q;
    logic                pend_q;
    logic [ADDR_W-1:0]   sample_q;
    logic                clr_pend_q;
    logic [ADDR_W-1:0]   clr_addr_q;
    logic [31:0]         total_q, total_d;
    logic [15:0]         dropped_q, dropped_d;
    logic [16:0]         drop_sum;

    logic [COUNT_W-1:0]  bin_mem_q [NBINS];
    logic [COUNT_W-1:0]  mem_q;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [COUNT_W-1:0]  mem_wdata;

    logic fall, in_clear, enter_clear, capture, sample_free;
    logic arm, drop_fall, drop_cap;

    assign fall        = prev_q & ~sync2_q;
    assign in_clear    = (state_q == S_CLEAR);
    assign enter_clear = (state_q == S_IDLE) && (clear_req || clr_pend_q);
    assign capture     = dly_run_q && (dly_cnt_q == DLY_W'(1));
    // The WRITE cycle is the last use of sample_q, so a capture then may reuse the slot.
    assign sample_free = !pend_q || (state_q == S_WRITE);

    assign arm       = fall && acq_enable && !in_clear && !enter_clear && !dly_run_q;
    assign drop_fall = fall && acq_enable && (in_clear || enter_clear || dly_run_q);
    assign drop_cap  = capture && !sample_free && !in_clear && !enter_clear;

    always_comb begin
        drop_sum  = {1'b0, dropped_q} + 17'(drop_fall) + 17'(drop_cap);
        dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        total_d   = total_q;
        if ((state_q == S_WRITE) && (total_q != 32'hFFFF_FFFF)) begin
            total_d = total_q + 32'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR:    if (clr_addr_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
            S_IDLE: begin
                if (clear_req || clr_pend_q) state_d = S_CLEAR;
                else if (pend_q)             state_d = S_READ;
                else if (rd_req)             state_d = S_HOST_RD;
            end
            S_READ:     state_d = S_WRITE;
            S_WRITE:    state_d = S_IDLE;
            S_HOST_RD:  state_d = S_HOST_RSP;
            S_HOST_RSP: state_d = S_IDLE;
            default:    state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        mem_addr  = sample_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            S_CLEAR: begin
                mem_addr = clr_addr_q;
                mem_we   = 1'b1;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = (&mem_q) ? mem_q : mem_q + COUNT_W'(1);
            end
            S_HOST_RD: mem_addr = rd_addr;
            default: ;
        endcase
    end

    // Write is gated by rst_n so nothing lands in the array while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            bin_mem_q[mem_addr] <= mem_wdata;
        end
        mem_q <= bin_mem_q[mem_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CLEAR;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            dly_run_q  <= 1'b0;
            dly_cnt_q  <= '0;
            pend_q     <= 1'b0;
            sample_q   <= '0;
            clr_pend_q <= 1'b0;
            clr_addr_q <= '0;
            total_q    <= '0;
            dropped_q  <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= comparator;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;

            if (enter_clear || in_clear) begin
                dly_run_q <= 1'b0;
                pend_q    <= 1'b0;
            end else begin
                if (arm) begin
                    dly_run_q <= 1'b1;
                    dly_cnt_q <= DLY_W'(SAMPLE_DELAY);
                end else if (dly_run_q) begin
                    if (capture) dly_run_q <= 1'b0;
                    dly_cnt_q <= dly_cnt_q - DLY_W'(1);
                end
                if (capture && sample_free) begin
                    pend_q   <= 1'b1;
                    sample_q <= adc_code;
                end else if (state_q == S_WRITE) begin
                    pend_q <= 1'b0;
                end
            end

            if (enter_clear) begin
                clr_pend_q <= 1'b0;
            end else if (clear_req && !in_clear && (state_q != S_IDLE)) begin
                clr_pend_q <= 1'b1;
            end

            if (enter_clear)   clr_addr_q <= '0;
            else if (in_clear) clr_addr_q <= clr_addr_q + ADDR_W'(1);

            if (enter_clear) begin
                total_q   <= '0;
                dropped_q <= '0;
            end else begin
                total_q   <= total_d;
                dropped_q <= dropped_d;
            end
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign rd_valid      = (state_q == S_HOST_RSP);
    assign rd_data       = rd_valid ? mem_q : '0;
    assign total_count   = total_q;
    assign dropped_count = dropped_q;
endmodule

// File: tb/tb_mca_spectrum_accumulator.sv
// tb/tb_mca_spectrum_accumulator.sv - self-checking bench for mca_spectrum_accumulator
`timescale 1ns/1ps
module tb_mca_spectrum_accumulator;
    localparam int AW  = 10;
    localparam int CW  = 4;
    localparam int SD  = 2;
    localparam int NB  = 1 << AW;
    localparam int MAXB = (1 << CW) - 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] exp;
    } rd_vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          comparator = 1'b0;
    logic [AW-1:0] adc_code = '0;
    logic          acq_enable = 1'b0;
    logic          clear_req = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [CW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic [31:0]   total_count;
    logic [15:0]   dropped_count;

    int checks = 0;
    int failures = 0;
    int model [NB];
    int model_total = 0;
    bit touched [NB];
    logic [AW-1:0] touched_q [$];

    mca_spectrum_accumulator #(.ADDR_W(AW), .COUNT_W(CW), .SAMPLE_DELAY(SD)) dut (
        .clk(clk), .rst_n(rst_n), .comparator(comparator), .adc_code(adc_code),
        .acq_enable(acq_enable), .clear_req(clear_req), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .total_count(total_count), .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [CW-1:0] d);
        bit got;
        got = 0;
        d = 'x;
        @(negedge clk);
        rd_addr = a;
        rd_req  = 1'b1;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (rd_valid) begin
                d   = rd_data;
                got = 1;
            end
        end
        rd_req = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL host_read_timeout: addr %0h got no rd_valid required within 2000 cycles", a);
        end
    endtask

    task automatic check_bin(input string name, input logic [AW-1:0] a, input int exp);
        logic [CW-1:0] d;
        host_read(a, d);
        check($sformatf("%s[%0h]", name, a), d, exp);
    endtask

    task automatic model_event(input logic [AW-1:0] code);
        if (!touched[code]) begin
            touched[code] = 1;
            touched_q.push_back(code);
        end
        if (acq_enable) begin
            model_total++;
            if (model[code] < MAXB) model[code]++;
        end
    endtask

    task automatic pulse(input logic [AW-1:0] code);
        @(negedge clk);
        comparator = 1'b1;
        @(negedge clk);
        comparator = 1'b0;
        adc_code   = code;
        model_event(code);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy(input logic level, input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (busy == level) break;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) model[i] = 0;
        model_total = 0;
    endtask

    initial begin
        rd_vec_t tbl [6];
        logic [AW-1:0] pool [4];
        logic [AW-1:0] code;
        int n;

        tbl[0] = '{addr: 10'h155, exp: 4'd5};
        tbl[1] = '{addr: 10'h010, exp: 4'd1};
        tbl[2] = '{addr: 10'h020, exp: 4'd0};
        tbl[3] = '{addr: 10'h3FF, exp: 4'd15};
        tbl[4] = '{addr: 10'h123, exp: 4'd0};
        tbl[5] = '{addr: 10'h000, exp: 4'd0};
        pool[0] = 10'h000; pool[1] = 10'h3FF; pool[2] = 10'h200; pool[3] = 10'h0AA;
        model_clear();

        repeat (3) @(negedge clk);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_total", total_count, 0);
        check("reset_dropped", dropped_count, 0);
        check("reset_busy", busy, 1);

        rst_n = 1'b1;
        wait_busy(1'b0, 3000, n);
        check("post_reset_sweep_cycles", n, NB);
        check_bin("init_bin", 10'h000, 0);
        check_bin("init_bin", 10'h1FF, 0);
        check_bin("init_bin", 10'h3FF, 0);

        acq_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pulse(10'h155);
            idle(18);
        end
        check_bin("five_pulse_bin", 10'h155, model[10'h155]);
        check("five_pulse_total", total_count, 5);
        check("five_pulse_dropped", dropped_count, 0);

        pulse(10'h010);
        @(negedge clk); comparator = 1'b1;
        @(negedge clk); comparator = 1'b0;
        idle(8);
        adc_code = 10'h020;
        idle(20);
        check("close_pair_dropped", dropped_count, 1);
        check("close_pair_total", total_count, 6);

        for (int i = 0; i < 14; i++) begin
            pulse(10'h3FF);
            idle(12);
        end
        check_bin("sat_pre", 10'h3FF, 14);
        for (int i = 0; i < 3; i++) begin
            pulse(10'h3FF);
            idle(12);
        end
        check_bin("sat_post", 10'h3FF, MAXB);
        check("sat_total", total_count, 23);

        acq_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse((i % 2) ? 10'h123 : 10'h155);
            idle(12);
        end
        @(negedge clk); comparator = 1'b1;
        @(negedge clk); comparator = 1'b0;
        @(negedge clk); comparator = 1'b1;
        @(negedge clk); comparator = 1'b0;
        idle(20);
        check("disabled_total", total_count, 23);
        check("disabled_dropped", dropped_count, 1);

        for (int i = 0; i < 6; i++) begin
            check_bin("table_bin", tbl[i].addr, tbl[i].exp);
        end

        acq_enable = 1'b1;
        pulse(10'h0F0);
        repeat (7) @(posedge clk);
        @(negedge clk); clear_req = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        wait_busy(1'b1, 10, n);
        check("clear_in_write_started", busy, 1);
        wait_busy(1'b0, 3000, n);
        check("clear_in_write_done", busy, 0);
        model_clear();
        check("cleared_total", total_count, 0);
        check("cleared_dropped", dropped_count, 0);
        check_bin("cleared_bin", 10'h155, 0);
        check_bin("cleared_bin", 10'h3FF, 0);
        check_bin("cleared_bin", 10'h0F0, 0);

        for (int i = 0; i < NB; i++) touched[i] = 0;
        touched_q.delete();
        for (int i = 0; i < 40; i++) begin
            acq_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) code = AW'($urandom_range(0, NB - 1));
            else                           code = pool[$urandom_range(0, 3)];
            pulse(code);
            idle($urandom_range(12, 20));
        end
        acq_enable = 1'b1;
        idle(20);
        check("random_total", total_count, model_total);
        check("random_dropped", dropped_count, 0);
        foreach (touched_q[i]) begin
            check_bin("random_bin", touched_q[i], model[touched_q[i]]);
        end
        for (int i = 0; i < 3; i++) begin
            code = AW'($urandom_range(0, NB - 1));
            check_bin("random_probe", code, model[code]);
        end

        @(negedge clk); clear_req = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        idle(300);
        rst_n = 1'b0;
        idle(2);
        check("midsweep_reset_busy", busy, 1);
        check("midsweep_reset_rd_valid", rd_valid, 0);
        rst_n = 1'b1;
        wait_busy(1'b0, 3000, n);
        check("midsweep_restart_cycles", n, NB);
        model_clear();
        check("midsweep_total", total_count, 0);
        check_bin("midsweep_bin", 10'h3FF, 0);
        check_bin("midsweep_bin", 10'h200, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
